// File: rtl/trig_emul_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : trig_emul_pkg                                          |
// | Description : Shared frame-format constants for the S-bit trigger    |
// |               frame emulator and its receiver-side counterparts.     |
// |               One VFAT frame is MXSBITS bits spread over NLANES      |
// |               serial lanes, FRAME_BITS bits per lane per frame.      |
// | Contents    : MXSBITS, NLANES, FRAME_BITS, SLOT_W, counter widths,   |
// |               slot_t, slot_onehot()                                  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package trig_emul_pkg;

   localparam int MXSBITS     = 64;
   localparam int NLANES      = 8;
   localparam int FRAME_BITS  = MXSBITS / NLANES;
   localparam int SLOT_W      = 3;
   localparam int FRAME_CNT_W = 12;
   localparam int UNDERRUN_W  = 16;

   typedef logic [SLOT_W-1:0] slot_t;

   // One-hot pattern with a single bit set in the requested slot. Used to
   // turn the SOF offset into an 8-bit "lane word" so the SOF output can
   // reuse the same serializer as the data lanes.
   function automatic logic [FRAME_BITS-1:0] slot_onehot(input slot_t slot);
      logic [FRAME_BITS-1:0] v;
      v       = '0;
      v[slot] = 1'b1;
      return v;
   endfunction

endpackage : trig_emul_pkg
`default_nettype wire

// File: rtl/trig_frame_emulator_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sbit_lane_serializer                                   |
// | Description : One serial lane of the trigger frame emulator. Holds   |
// |               an 8-bit lane word, emits it LSB-first one bit per     |
// |               clock, applies the data mask and output polarity and   |
// |               registers the result.                                  |
// | Ports       : clock, reset_i     clock / async active-high reset     |
// |               run                lane active; low forces logical 0   |
// |               load               frame boundary, take load_data      |
// |               load_data[7:0]     lane word for the next frame        |
// |               mask               force data bit to 0 (pre-invert)    |
// |               invert             output polarity                     |
// |               serial_bit         registered serial output            |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module sbit_lane_serializer
   import trig_emul_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset_i,
   input  logic                  run,
   input  logic                  load,
   input  logic [FRAME_BITS-1:0] load_data,
   input  logic                  mask,
   input  logic                  invert,
   output logic                  serial_bit
);

   logic [FRAME_BITS-1:0] r_shift;
   logic                  r_bit;
   logic [FRAME_BITS-1:0] w_cur;
   logic                  w_data_bit;

   // On a load cycle the new word bypasses the shift register so that its
   // slot-0 bit reaches the output flop on the very next edge.
   always_comb begin
      w_cur      = load ? load_data : r_shift;
      w_data_bit = run & w_cur[0] & ~mask;
   end

   always_ff @(posedge clock or posedge reset_i) begin
      if (reset_i) begin
         r_shift <= '0;
         r_bit   <= 1'b0;
      end else begin
         r_shift <= {1'b0, w_cur[FRAME_BITS-1:1]};
         r_bit   <= w_data_bit ^ invert;
      end
   end

   assign serial_bit = r_bit;

endmodule : sbit_lane_serializer
`default_nettype wire

// File: rtl/trig_frame_emulator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : trig_frame_emulator                                    |
// | Description : Transmit-side S-bit frame source. Accepts 64-bit VFAT  |
// |               frames over valid/ready into a one-deep holding        |
// |               register and serializes them onto 8 trigger lanes      |
// |               plus a start-of-frame lane, one bit per lane per clock.|
// | Ports       : clock, reset_i      clock / async active-high reset    |
// |               enable              run frame sequencing               |
// |               sof_offset[2:0]     slot in which SOF asserts          |
// |               invert[8:0]         polarity: [7:0] lanes, [8] SOF     |
// |               mask                zero the transmitted data          |
// |               sbits_i[63:0]       frame payload, bit lane*8+slot     |
// |               valid_i / ready_o   input handshake                    |
// |               sbits_o[7:0]        serial lane outputs                |
// |               sof_o               serial start-of-frame              |
// |               frame_strobe        pulse with slot 0 of each frame    |
// |               frame_cnt[11:0]     frames transmitted, wrapping       |
// |               underrun_cnt[15:0]  empty frames while armed, saturates|
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module trig_frame_emulator
   import trig_emul_pkg::*;
(
   input  logic                   clock,
   input  logic                   reset_i,
   input  logic                   enable,
   input  logic [SLOT_W-1:0]      sof_offset,
   input  logic [NLANES:0]        invert,
   input  logic                   mask,
   input  logic [MXSBITS-1:0]     sbits_i,
   input  logic                   valid_i,
   output logic                   ready_o,
   output logic [NLANES-1:0]      sbits_o,
   output logic                   sof_o,
   output logic                   frame_strobe,
   output logic [FRAME_CNT_W-1:0] frame_cnt,
   output logic [UNDERRUN_W-1:0]  underrun_cnt
);

   localparam slot_t c_LAST_SLOT = slot_t'(FRAME_BITS - 1);

   // r_slot is the slot currently visible on the outputs; r_active says
   // the outputs are carrying a frame (enable was high last cycle).
   logic                   r_active;
   slot_t                  r_slot;
   logic [MXSBITS-1:0]     r_hold;
   logic                   r_hold_valid;
   logic                   r_armed;
   logic                   r_mask_q;
   logic                   r_strobe;
   logic [FRAME_CNT_W-1:0] r_frame_cnt;
   logic [UNDERRUN_W-1:0]  r_underrun_cnt;

   logic                   w_load;
   logic                   w_ready;
   logic                   w_accept;
   logic                   w_mask_eff;
   logic [MXSBITS-1:0]     w_frame;
   logic [FRAME_BITS-1:0]  w_sof_pattern;

   // A frame boundary is either the last slot of a running frame or the
   // first enabled cycle after idle; either way the next output is slot 0.
   assign w_load   = enable & (~r_active | (r_slot == c_LAST_SLOT));
   // The holding register can take a new word in the same cycle it hands
   // its current contents to the serializers.
   assign w_ready  = ~r_hold_valid | w_load;
   assign w_accept = valid_i & w_ready;

   always_comb begin
      w_frame       = r_hold_valid ? r_hold : '0;
      // mask is frame-constant: sampled at the boundary, bypassed on the
      // load cycle itself so slot 0 already sees the new value.
      w_mask_eff    = w_load ? mask : r_mask_q;
      w_sof_pattern = slot_onehot(sof_offset);
   end

   // ---------------------------------------------------------------
   // Slot sequencing
   // ---------------------------------------------------------------
   always_ff @(posedge clock or posedge reset_i) begin
      if (reset_i) begin
         r_active <= 1'b0;
         r_slot   <= '0;
         r_strobe <= 1'b0;
         r_mask_q <= 1'b0;
      end else begin
         r_active <= enable;
         // The first enabled cycle loads but keeps slot 0 for the cycle
         // that actually shows slot 0; afterwards the counter wraps 7->0
         // on its own, which lines up with the slot-7 boundary.
         if (enable && r_active) begin
            r_slot <= r_slot + slot_t'(1);
         end else begin
            r_slot <= '0;
         end
         r_strobe <= w_load;
         if (w_load) begin
            r_mask_q <= mask;
         end
      end
   end

   // ---------------------------------------------------------------
   // Handshake / holding register
   // ---------------------------------------------------------------
   always_ff @(posedge clock or posedge reset_i) begin
      if (reset_i) begin
         r_hold       <= '0;
         r_hold_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            r_hold       <= sbits_i;
            r_hold_valid <= 1'b1;
         end else if (w_load) begin
            r_hold_valid <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------
   // Arming and statistics
   // ---------------------------------------------------------------
   always_ff @(posedge clock or posedge reset_i) begin
      if (reset_i) begin
         r_armed        <= 1'b0;
         r_frame_cnt    <= '0;
         r_underrun_cnt <= '0;
      end else begin
         // Underruns only count once a source has shown up in this
         // enable window; an idle emulator is not starving.
         r_armed <= enable & (r_armed | w_accept);
         if (w_load) begin
            r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
            if (!r_hold_valid && r_armed && (r_underrun_cnt != '1)) begin
               r_underrun_cnt <= r_underrun_cnt + UNDERRUN_W'(1);
            end
         end
      end
   end

   // ---------------------------------------------------------------
   // Serializers: one per data lane, one for SOF
   // ---------------------------------------------------------------
   for (genvar i = 0; i < NLANES; i++) begin : g_lane
      sbit_lane_serializer u_lane (
         .clock      (clock),
         .reset_i    (reset_i),
         .run        (enable),
         .load       (w_load),
         .load_data  (w_frame[i*FRAME_BITS +: FRAME_BITS]),
         .mask       (w_mask_eff),
         .invert     (invert[i]),
         .serial_bit (sbits_o[i])
      );
   end : g_lane

   // SOF is a lane whose word is the one-hot of the frame's SOF offset;
   // it is never masked.
   sbit_lane_serializer u_sof (
      .clock      (clock),
      .reset_i    (reset_i),
      .run        (enable),
      .load       (w_load),
      .load_data  (w_sof_pattern),
      .mask       (1'b0),
      .invert     (invert[NLANES]),
      .serial_bit (sof_o)
   );

   assign ready_o      = w_ready;
   assign frame_strobe = r_strobe;
   assign frame_cnt    = r_frame_cnt;
   assign underrun_cnt = r_underrun_cnt;

endmodule : trig_frame_emulator
`default_nettype wire

// File: tb/tb_trig_frame_emulator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_trig_frame_emulator                                 |
// | Description : Self-checking bench for trig_frame_emulator. A frame-  |
// |               level reference model tracks enable run length, the    |
// |               holding register and counters; every cycle the DUT     |
// |               outputs are compared against it. Directed phases pin   |
// |               literal values, then a randomized phase runs.          |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_trig_frame_emulator;

   logic        clock = 1'b0;
   logic        reset_i;
   logic        enable;
   logic [2:0]  sof_offset;
   logic [8:0]  invert;
   logic        mask;
   logic [63:0] sbits_i;
   logic        valid_i;
   logic        ready_o;
   logic [7:0]  sbits_o;
   logic        sof_o;
   logic        frame_strobe;
   logic [11:0] frame_cnt;
   logic [15:0] underrun_cnt;

   int n_pass  = 0;
   int n_total = 0;

   trig_frame_emulator dut (
      .clock        (clock),
      .reset_i      (reset_i),
      .enable       (enable),
      .sof_offset   (sof_offset),
      .invert       (invert),
      .mask         (mask),
      .sbits_i      (sbits_i),
      .valid_i      (valid_i),
      .ready_o      (ready_o),
      .sbits_o      (sbits_o),
      .sof_o        (sof_o),
      .frame_strobe (frame_strobe),
      .frame_cnt    (frame_cnt),
      .underrun_cnt (underrun_cnt)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // ------------------------------------------------------------------
   // Reference model. m_run counts consecutive enabled clock edges; a
   // frame starts whenever that count is a multiple of 8.
   // ------------------------------------------------------------------
   int          m_run   = 0;
   logic        m_hv    = 1'b0;
   logic [63:0] m_hold  = '0;
   logic        m_armed = 1'b0;
   logic [63:0] m_frame = '0;
   logic        m_mask  = 1'b0;
   logic [2:0]  m_off   = '0;
   logic [11:0] m_fc    = '0;
   logic [15:0] m_uc    = '0;
   int          m_acc   = 0;
   logic [7:0]  e_sbits = '0;
   logic        e_sof   = 1'b0;
   logic        e_strobe = 1'b0;

   always @(posedge clock or posedge reset_i) begin
      if (reset_i) begin
         m_run = 0; m_hv = 1'b0; m_armed = 1'b0; m_frame = '0;
         m_mask = 1'b0; m_off = '0; m_fc = '0; m_uc = '0;
         e_sbits = '0; e_sof = 1'b0; e_strobe = 1'b0;
      end else begin
         logic boundary, accept;
         int   s;
         boundary = enable && (m_run % 8 == 0);
         accept   = valid_i && (!m_hv || boundary);
         if (boundary) begin
            if (m_armed && !m_hv && m_uc != 16'hFFFF) m_uc = m_uc + 16'd1;
            m_fc    = m_fc + 12'd1;
            m_frame = m_hv ? m_hold : 64'd0;
            m_mask  = mask;
            m_off   = sof_offset;
         end
         if (accept) begin
            m_hold = sbits_i; m_hv = 1'b1; m_acc++;
         end else if (boundary) begin
            m_hv = 1'b0;
         end
         m_armed  = enable && (m_armed || accept);
         e_strobe = boundary;
         if (enable) begin
            s = m_run % 8;
            for (int i = 0; i < 8; i++)
               e_sbits[i] = (m_frame[i*8+s] & ~m_mask) ^ invert[i];
            e_sof = (s == int'(m_off)) ^ invert[8];
            m_run++;
         end else begin
            e_sbits = invert[7:0];
            e_sof   = invert[8];
            m_run   = 0;
         end
      end
   end

   // Per-cycle comparison, away from the active edge.
   always @(negedge clock) begin
      logic e_ready;
      #1;
      e_ready = reset_i ? 1'b1 : (!m_hv || (enable && (m_run % 8 == 0)));
      chk("sbits_o",      sbits_o,      e_sbits);
      chk("sof_o",        sof_o,        e_sof);
      chk("frame_strobe", frame_strobe, e_strobe);
      chk("frame_cnt",    frame_cnt,    m_fc);
      chk("underrun_cnt", underrun_cnt, m_uc);
      chk("ready_o",      ready_o,      e_ready);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Waits (bounded) for the next frame strobe, then records one frame.
   task automatic capture(output logic [7:0] lane0, output logic [7:0] lane7,
                          output logic [7:0] sofb, output logic [7:0] lanes_and);
      int n;
      n = 0;
      do begin @(negedge clock); #2; n++; end while (!frame_strobe && n < 20);
      chk("strobe_seen", frame_strobe, 1'b1);
      lanes_and = 8'hFF;
      for (int s = 0; s < 8; s++) begin
         if (s > 0) begin @(negedge clock); #2; end
         lane0[s]  = sbits_o[0];
         lane7[s]  = sbits_o[7];
         sofb[s]   = sof_o;
         lanes_and = lanes_and & sbits_o;
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_i = 1'b1;
      cyc(2);
      reset_i = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] l0, l7, sb, la;
      int base;
      reset_i = 1'b1; enable = 1'b0; sof_offset = '0; invert = '0;
      mask = 1'b0; sbits_i = '0; valid_i = 1'b0;
      cyc(3);
      reset_i = 1'b0;

      // Idle source: SOF in slot 0, lanes quiet, never armed.
      enable = 1'b1;
      capture(l0, l7, sb, la);
      chk("idle_sof_slot0", sb, 8'h01);
      chk("idle_lane0", l0, 8'h00);
      cyc(16);
      chk("idle_underrun", underrun_cnt, 16'd0);

      // Known pattern, injected just after a boundary.
      capture(l0, l7, sb, la);
      sbits_i = 64'h0123456789ABCDEF; valid_i = 1'b1;
      @(negedge clock);
      valid_i = 1'b0;
      capture(l0, l7, sb, la);
      chk("pattern_lane0", l0, 8'hEF);
      chk("pattern_lane7", l7, 8'h01);
      chk("pattern_sof", sb, 8'h01);

      // Back-to-back source: ten frames in 73 enabled edges.
      enable = 1'b0;
      do_reset();
      valid_i = 1'b1;
      for (int c = 0; c < 2; c++) begin sbits_i = {$urandom, $urandom}; @(negedge clock); end
      enable = 1'b1;
      for (int c = 0; c < 78; c++) begin sbits_i = {$urandom, $urandom}; @(negedge clock); end
      #2;
      chk("b2b_frame_cnt", frame_cnt, 12'd10);
      chk("b2b_underrun", underrun_cnt, 16'd0);
      @(negedge clock);
      enable = 1'b0; valid_i = 1'b0;

      // Source stops after three words: five empty frames follow.
      do_reset();
      base = m_acc;
      enable = 1'b1; valid_i = 1'b1; sbits_i = {$urandom, $urandom};
      for (int c = 0; c < 70; c++) begin
         @(negedge clock);
         if (m_acc >= base + 3) valid_i = 1'b0;
         else sbits_i = {$urandom, $urandom};
      end
      #2;
      chk("stop_underrun", underrun_cnt, 16'd5);
      @(negedge clock);
      enable = 1'b0;
      cyc(20);
      enable = 1'b1;
      cyc(30);
      #2;
      chk("disarmed_underrun", underrun_cnt, 16'd5);

      // Offset, full inversion and mask.
      @(negedge clock);
      sof_offset = 3'd5; invert = 9'h1FF; mask = 1'b1;
      valid_i = 1'b1; sbits_i = 64'hFFFF_0000_A5A5_5A5A;
      capture(l0, l7, sb, la);
      chk("inv_sof_slot5", sb, 8'hDF);
      chk("inv_mask_lanes", la, 8'hFF);
      @(negedge clock);
      valid_i = 1'b0; mask = 1'b0; invert = 9'h000; sof_offset = 3'd0;

      // Randomized traffic.
      for (int c = 0; c < 1500; c++) begin
         @(negedge clock);
         if ($urandom_range(0, 39) == 0) enable = ~enable;
         valid_i    = ($urandom_range(0, 3) != 0);
         sbits_i    = {$urandom, $urandom};
         sof_offset = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 49) == 0) invert = 9'($urandom_range(0, 511));
         if ($urandom_range(0, 29) == 0) mask = ~mask;
      end

      // Asynchronous reset mid-frame with the holding register full.
      @(negedge clock);
      enable = 1'b1; valid_i = 1'b1; invert = 9'h0A5;
      cyc(12);
      #2;
      reset_i = 1'b1;
      #1;
      chk("areset_sbits", sbits_o, 8'h00);
      chk("areset_sof", sof_o, 1'b0);
      chk("areset_strobe", frame_strobe, 1'b0);
      chk("areset_ready", ready_o, 1'b1);
      chk("areset_frame_cnt", frame_cnt, 12'd0);
      chk("areset_underrun", underrun_cnt, 16'd0);
      cyc(2);
      reset_i = 1'b0;
      valid_i = 1'b0;
      cyc(20);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_trig_frame_emulator
`default_nettype wire

// File: doc/trig_frame_emulator.md
# trig_frame_emulator

Transmit-side counterpart of the S-bit trigger receiver: serializes one VFAT's 64 S-bits per frame onto 8 trigger lanes plus a start-of-frame (SOF) lane, one bit per lane per clock, matching the 8-bit-per-frame format the receiver's frame aligner expects. It is used as a loopback/test-pattern source in front of the oversampler/aligner chain and as a VFAT3 stand-in on bench firmware. Parallel frames enter through a valid/ready handshake with one frame of buffering. Programmable SOF offset and per-lane polarity exercise receiver alignment and inversion handling.

## Interface
- MXSBITS, 64, S-bits per frame
- NLANES, 8, trigger lanes
- FRAME_BITS, 8, bits per lane per frame (MXSBITS/NLANES)
- clock  in  1  bit clock; all logic is on the rising edge
- reset_i  in  1  asynchronous, active-high reset
- enable  in  1  run frame sequencing; low = idle, outputs logical 0
- sof_offset  in  3  bit slot (0..7) in which sof_o asserts
- invert  in  9  polarity per output; [7:0] lanes, [8] SOF
- mask  in  1  forces transmitted data to 0 (SOF unaffected)
- sbits_i  in  MXSBITS  frame payload; bit lane*8+slot
- valid_i  in  1  sbits_i valid
- ready_o  out  1  holding register can accept
- sbits_o  out  NLANES  serial lane outputs
- sof_o  out  1  serial start-of-frame
- frame_strobe  out  1  one-cycle pulse on slot 0 of each transmitted frame
- frame_cnt  out  12  transmitted frames, wrapping
- underrun_cnt  out  16  frames sent empty while armed, saturating

## Operation
- Slot counter 0..7 free-runs while enable=1; held at 0 while enable=0.
- Holding register (hold, hold_valid): loaded when valid_i && ready_o. ready_o = !hold_valid || load. Accepts regardless of enable.
- Frame boundary = cycle where slot==7 (or first cycle after enable rises, slot 0). At boundary ("load"): shift register <- hold if hold_valid else all zeros; hold_valid cleared unless a new word is accepted the same cycle (simultaneous load+accept keeps hold_valid=1 with new data).
- sof_offset and mask sampled at load; constant for the frame.
- Lane i output in slot s = shreg[i*8+s] & ~mask_q, XOR invert[i]. sof_o = (slot==sof_offset_q) XOR invert[8]. invert applied combinationally before output flop; may change any time.
- Armed set on first accepted word after enable rises; cleared when enable=0. Underrun: load with hold_valid=0 while armed -> underrun_cnt+1, saturating at 0xFFFF.
- frame_cnt increments on every load while enable=1; wraps 4095->0.
- enable falling mid-frame: current frame abandoned immediately, slot->0, outputs logical 0 next cycle; hold contents retained.

## Timing
- Reset values: sbits_o=0, sof_o=0, frame_strobe=0, ready_o=1, frame_cnt=0, underrun_cnt=0, hold_valid=0, slot=0, armed=0.
- After reset release, outputs follow invert (logical 0) from the first clock.
- All outputs registered. Load at cycle t -> slot-0 bit and frame_strobe on outputs at t+1; slot-7 bit at t+8.
- Word accepted into empty hold at cycle a: transmitted starting the cycle after the next boundary (1..8 cycles latency).
- Sustained throughput: one frame per 8 cycles; ready_o can stay high continuously when source supplies one word per frame.

## Structure
- Package trig_emul_pkg: MXSBITS, NLANES, FRAME_BITS, SLOT_W=3 constants shared with the receiver bench.
- One sub-module natural: sbit_lane_serializer (8-bit shift/select, mask, invert, output flop), instantiated NLANES times plus once for SOF.
- Top holds slot counter, handshake/holding register, counters.

## Test plan
- Reset, enable=1, no data, invert=0 -> lanes 0, sof_o high in slot 0 every 8 cycles, underrun_cnt stays 0 (not armed).
- sbits_i=64'h0123456789ABCDEF accepted -> lane 0 emits 0xEF LSB-first, lane 7 emits 0x01; frame_strobe aligned to first bit.
- Back-to-back valid_i for 10 frames -> 10 frames sent contiguously, frame_cnt=10, underrun_cnt=0; ready_o low only when hold full before load.
- Stop source after 3 frames, run 5 more frames -> underrun_cnt=5, lanes 0; enable low resets armed, no further counting.
- sof_offset=5, invert=9'h1FF -> sof_o low only in slot 5; all lane bits complemented; mask=1 -> lanes constant 1 (inverted 0).
- reset_i asserted mid-frame with hold full -> all outputs/counters to reset values asynchronously, ready_o=1.
